// File: rtl/dmem_responder_pkg.sv
// Shared types and default parameters for the dmem_responder data-memory slave.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word storage with synchronous byte-enable write and asynchronous read.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage is deliberately never reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder, one outstanding transaction.
// Optional misalignment error reporting: define DMEM_RESPONDER_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          write_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          commit;
  logic          acc_write;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          misaligned;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [31:0]   rdata_d;
  logic          unused_addr;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign commit = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                  (accept && (WAIT_CYCLES == 0));

  // With zero wait states the access happens on the accept edge, so use live inputs.
  assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr[AW+1:0] : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == ST_IDLE) ? req_be : be_q;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = (acc_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign unused_addr = ^{req_addr[31:AW+2], acc_addr[1:0]};

  assign mem_we  = commit && acc_write && !misaligned;
  assign rdata_d = (acc_write || misaligned) ? 32'h0 : mem_rdata;

  dmem_responder_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clock   (clock),
    .we_i    (mem_we),
    .be_i    (acc_be),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              rdata_q <= rdata_d;
              err_q   <= misaligned;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            rdata_q <= rdata_d;
            err_q   <= misaligned;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with a transaction-level reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a word-indexed memory plus the transaction in flight.
  logic [31:0] modelMem [int];
  bit          mBusy = 1'b0;
  int          mAge = 0;
  bit          mWrite;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [3:0]  mBe;
  logic [31:0] mData = 32'h0;
  logic        mErr = 1'b0;
  bit          mKnown = 1'b1;

  task automatic modelResolve();
    int idx;
    logic [31:0] word;
    idx = int'((mAddr / 4) % DEPTH);
    mData  = 32'h0;
    mErr   = 1'b0;
    mKnown = 1'b1;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    if (mAddr % 4 != 0) begin
      mErr = 1'b1;
      return;
    end
`endif
    if (mWrite) begin
      if (modelMem.exists(idx) || mBe == 4'hF) begin
        word = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (mBe[b]) word[8*b +: 8] = mWdata[8*b +: 8];
        modelMem[idx] = word;
      end
    end else if (modelMem.exists(idx)) begin
      mData = modelMem[idx];
    end else begin
      mKnown = 1'b0;
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mBusy = 1'b0;
      mAge  = 0;
    end else if (mBusy) begin
      if (mAge == W + 1) begin
        if (resp_ready) mBusy = 1'b0;
      end else begin
        mAge++;
        if (mAge == W + 1) modelResolve();
      end
    end else if (req_valid) begin
      mBusy  = 1'b1;
      mAge   = 0;
      mWrite = req_write;
      mAddr  = req_addr;
      mWdata = req_wdata;
      mBe    = req_be;
      if (W == 0) begin
        mAge = 1;
        modelResolve();
      end
    end
  end

  always @(negedge clock) begin
    if (reset && checkEn) begin
      checkOutput("req_ready", {31'h0, req_ready}, {31'h0, !mBusy});
      checkOutput("resp_valid", {31'h0, resp_valid}, {31'h0, mBusy && (mAge == W + 1)});
      if (resp_valid && mBusy && (mAge == W + 1)) begin
        if (mKnown) checkOutput("resp_rdata", resp_rdata, mData);
        checkOutput("resp_err", {31'h0, resp_err}, {31'h0, mErr});
      end
    end
  end

  // One full transaction; abortEdges >= 0 pulls reset that many edges after accept.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int holdCycles, input int abortEdges,
                               output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    rdata = 32'h0;
    err   = 1'b0;
    lat   = -1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_write = ~wr;
    req_addr  = 32'h44;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    if (abortEdges >= 0) begin
      repeat (abortEdges) begin
        @(posedge clock); #1;
      end
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("abortRespValid", {31'h0, resp_valid}, 32'h0);
      checkOutput("abortRdata", resp_rdata, 32'h0);
      checkOutput("abortErr", {31'h0, resp_err}, 32'h0);
      @(negedge clock); #2;
      reset = 1'b1;
      return;
    end
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    req_valid = 1'b0;
    if (!resp_valid) begin
      checkOutput("respTimeout", 32'h0, 32'h1);
      return;
    end
    repeat (holdCycles) begin
      @(posedge clock); #1;
      checkOutput("holdValid", {31'h0, resp_valid}, 32'h1);
      checkOutput("holdReqReady", {31'h0, req_ready}, 32'h0);
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    #12;
    checkOutput("rstRespValid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rstRdata", resp_rdata, 32'h0);
    checkOutput("rstErr", {31'h0, resp_err}, 32'h0);
    @(negedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rstReqReady", {31'h0, req_ready}, 32'h1);
    checkEn = 1'b1;

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, -1, rd, er, lat);
    checkOutput("storeLatency", lat, 32'd3);
    checkOutput("storeRdata", rd, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("loadLatency", lat, 32'd3);
    checkOutput("loadRdata", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0, -1, rd, er, lat);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, -1, rd, er, lat);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 5, -1, rd, er, lat);
    checkOutput("mergeRdata", rd, 32'h11BB33DD);

    applyStimulus(1'b1, 32'h400, 32'h5, 4'hF, 0, -1, rd, er, lat);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("wrapRdata", rd, 32'h5);

    applyStimulus(1'b1, 32'h10, 32'h01020304, 4'h0, 0, -1, rd, er, lat);
    checkOutput("noopLatency", lat, 32'd3);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("noopRdata", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h30, 32'h12345678, 4'hF, 0, -1, rd, er, lat);
    applyStimulus(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 0, 1, rd, er, lat);
    @(posedge clock); #1;
    checkOutput("postAbortReqReady", {31'h0, req_ready}, 32'h1);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("abortRdataKept", rd, 32'h12345678);

    applyStimulus(1'b0, 32'h13, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("misLoadLatency", lat, 32'd3);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    checkOutput("misLoadErr", {31'h0, er}, 32'h1);
    checkOutput("misLoadRdata", rd, 32'h0);
    applyStimulus(1'b1, 32'h11, 32'h99999999, 4'hF, 0, -1, rd, er, lat);
    checkOutput("misStoreErr", {31'h0, er}, 32'h1);
`else
    checkOutput("misLoadErr", {31'h0, er}, 32'h0);
    checkOutput("misLoadRdata", rd, 32'hDEADBEEF);
`endif
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, -1, rd, er, lat);
    checkOutput("finalRdata", rd, 32'hDEADBEEF);
    checkOutput("finalErr", {31'h0, er}, 32'h0);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words stored (power of two, >= 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i gates byte i.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  misaligned-access flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding transaction maximum.
REQ-016 SHALL drive req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-017 SHALL, in IDLE on req_valid&req_ready, capture write, addr, wdata, be; go to WAIT with counter=WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-018 SHALL decrement the counter each WAIT cycle and enter RESP on the edge where it reaches 0; resp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 SHALL perform the memory access on the edge entering RESP: stores merge wdata bytes where be=1; loads latch the full word into resp_rdata.
REQ-020 SHALL index the word as addr[log2(DEPTH)+1:2]; upper address bits ignored (addresses wrap modulo 4*DEPTH).
REQ-021 SHALL hold resp_rdata and resp_err stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL, on resp_valid&resp_ready, return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-023 SHALL treat a store with be=4'b0000 as a no-op that still completes with a response.
REQ-024 SHALL make a load following a store to the same word return the stored data.
REQ-025 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-026 SHALL, on reset low, immediately force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 after reset deasserts.
REQ-027 SHALL abandon an in-flight transaction on reset mid-operation; an uncommitted store SHALL not modify memory.
REQ-028 SHALL not clear storage contents on reset.

Configuration
REQ-029 SHALL, with DMEM_RESPONDER_ALIGN_CHECK_EN defined, treat req_addr[1:0]!=0 as an error: no memory access, resp_err=1, resp_rdata=0, same latency.
REQ-030 SHALL, without DMEM_RESPONDER_ALIGN_CHECK_EN, ignore req_addr[1:0] and tie resp_err to 0.

Structure
REQ-031 SHALL place the FSM state enumeration and default DEPTH/WAIT_CYCLES constants in shared package dmem_responder_pkg.
REQ-032 SHALL instantiate one sub-module dmem_responder_array: synchronous byte-enable write, single port.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=2, store 0xDEADBEEF be=4'hF addr 0x10, then load 0x10 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF.
REQ-034 SHALL cover: word 0x11223344 at 0x20, store 0xAABBCCDD be=4'b0101 -> load returns 0x11BB33DD.
REQ-035 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and rdata stable, req_ready 0 throughout.
REQ-036 SHALL cover: DEPTH=256, store 0x5 to addr 0x400, load addr 0x0 -> rdata 0x5 (wrap).
REQ-037 SHALL cover: reset asserted during WAIT of store 0xFFFFFFFF to 0x30 -> resp_valid 0, later load 0x30 returns prior value.
REQ-038 SHALL cover: with DMEM_RESPONDER_ALIGN_CHECK_EN, load addr 0x13 -> resp_err 1, rdata 0; memory unchanged.
